// File: rtl/match_checker_pkg.sv
// Shared types and default sizing for the match checker block.
package match_checker_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/match_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over increment so a window can open on the same edge.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/match_checker.sv
// Windowed comparator of q_ref against q_dut: counts qualified samples and mismatches,
// records the first failing cycle and a sticky bit-error mask, then holds a report.
module match_checker
    import match_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic [WIDTH-1:0] q_ref,
    input  logic [WIDTH-1:0] q_dut,
    output logic             mismatch,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] err_bits,
    output logic             report_valid,
    input  logic             report_ready
);

    state_e           state_q, state_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic [CNT_W-1:0] first_err_cycle_q, first_err_cycle_d;
    logic             first_err_valid_q, first_err_valid_d;

    logic             enter_run;
    logic             in_run;
    logic             take;
    logic             differ;
    logic [WIDTH-1:0] diff_bits;
    logic [CNT_W-1:0] cycle_cnt;

    assign enter_run = (state_q == IDLE) && start;
    assign in_run    = (state_q == RUN);
    assign take      = in_run && en;
    assign diff_bits = q_ref ^ q_dut;
    assign differ    = (diff_bits != '0);

    // Errors only ever advance alongside samples, so errors <= samples holds by construction.
    sat_counter #(.CNT_W(CNT_W)) u_samples (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_run),
        .inc   (take),
        .count (samples)
    );

    sat_counter #(.CNT_W(CNT_W)) u_errors (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_run),
        .inc   (take && differ),
        .count (errors)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_run),
        .inc   (in_run),
        .count (cycle_cnt)
    );

    always_comb begin
        state_d           = state_q;
        mismatch_d        = mismatch_q;
        err_bits_d        = err_bits_q;
        first_err_cycle_d = first_err_cycle_q;
        first_err_valid_d = first_err_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d           = RUN;
                    mismatch_d        = 1'b0;
                    err_bits_d        = '0;
                    first_err_cycle_d = '0;
                    first_err_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (en) begin
                    mismatch_d = differ;
                    if (differ) begin
                        err_bits_d = err_bits_q | diff_bits;
                        if (!first_err_valid_q) begin
                            first_err_cycle_d = cycle_cnt;
                            first_err_valid_d = 1'b1;
                        end
                    end
                end
                // The sample in the stop cycle has already been taken above.
                if (stop) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (report_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            mismatch_q        <= 1'b0;
            err_bits_q        <= '0;
            first_err_cycle_q <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            mismatch_q        <= mismatch_d;
            err_bits_q        <= err_bits_d;
            first_err_cycle_q <= first_err_cycle_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign mismatch        = mismatch_q;
    assign err_bits        = err_bits_q;
    assign first_err_cycle = first_err_cycle_q;
    assign first_err_valid = first_err_valid_q;
    assign report_valid    = (state_q == REPORT);

endmodule

// File: tb/tb_match_checker.sv
// Directed bench for match_checker: a default instance plus a CNT_W=4 instance sharing stimulus.
module tb_match_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic [7:0] q_ref = 8'h00;
    logic [7:0] q_dut = 8'h00;
    logic       report_ready = 1'b0;

    logic        mismatch, first_err_valid, report_valid;
    logic [15:0] samples, errors, first_err_cycle;
    logic [7:0]  err_bits;

    logic       mismatch4, first_err_valid4, report_valid4;
    logic [3:0] samples4, errors4, first_err_cycle4;
    logic [7:0] err_bits4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    match_checker #(.WIDTH(8), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .en              (en),
        .q_ref           (q_ref),
        .q_dut           (q_dut),
        .mismatch        (mismatch),
        .samples         (samples),
        .errors          (errors),
        .first_err_cycle (first_err_cycle),
        .first_err_valid (first_err_valid),
        .err_bits        (err_bits),
        .report_valid    (report_valid),
        .report_ready    (report_ready)
    );

    match_checker #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .en              (en),
        .q_ref           (q_ref),
        .q_dut           (q_dut),
        .mismatch        (mismatch4),
        .samples         (samples4),
        .errors          (errors4),
        .first_err_cycle (first_err_cycle4),
        .first_err_valid (first_err_valid4),
        .err_bits        (err_bits4),
        .report_valid    (report_valid4),
        .report_ready    (report_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic s, input logic p, input logic e,
                       input logic [7:0] r, input logic [7:0] d);
        start = s;
        stop  = p;
        en    = e;
        q_ref = r;
        q_dut = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        report_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        report_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] d;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_samples", samples, 0);
        chk("rst_errors", errors, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_fev", first_err_valid, 0);
        chk("rst_err_bits", err_bits, 0);
        chk("rst_rv", report_valid, 0);
        reset = 1'b0;

        // Clean window: 10 matching samples of 0xA5
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) cyc(1'b0, i == 9, 1'b1, 8'hA5, 8'hA5);
        chk("clean_rv", report_valid, 1);
        chk("clean_samples", samples, 10);
        chk("clean_errors", errors, 0);
        chk("clean_fev", first_err_valid, 0);
        chk("clean_err_bits", err_bits, 8'h00);
        chk("clean_mismatch", mismatch, 0);
        drain();
        chk("clean_idle_rv", report_valid, 0);
        chk("clean_idle_hold", samples, 10);
        $display("txn clean window: samples=%0d errors=%0d", samples, errors);

        // Errors at cycles 3 and 7; stop at cycle 9
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            r = 8'h30 + 8'(i);
            d = r ^ ((i == 3) ? 8'h01 : (i == 7) ? 8'h81 : 8'h00);
            cyc(1'b0, i == 9, 1'b1, r, d);
            if (i == 3) begin
                chk("err_mismatch_c3", mismatch, 1);
                chk("err_fec_c3", first_err_cycle, 3);
            end
            if (i == 4) chk("err_mismatch_c4", mismatch, 0);
        end
        chk("err_rv", report_valid, 1);
        chk("err_samples", samples, 10);
        chk("err_errors", errors, 2);
        chk("err_fec", first_err_cycle, 3);
        chk("err_fev", first_err_valid, 1);
        chk("err_err_bits", err_bits, 8'h81);
        drain();
        $display("txn error window: errors=%0d first=%0d bits=%0h", errors, first_err_cycle, err_bits);

        // en alternating over 8 RUN cycles, every sample mismatching
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, i == 7, (i % 2) == 0, 8'h0F, 8'hF0);
            if (i == 1) chk("alt_mismatch_hold", mismatch, 1);
        end
        chk("alt_samples", samples, 4);
        chk("alt_errors", errors, 4);
        chk("alt_fec", first_err_cycle, 0);
        chk("alt_err_bits", err_bits, 8'hFF);
        $display("txn alternating en: samples=%0d errors=%0d", samples, errors);

        // REPORT held while other inputs toggle
        for (int k = 0; k < 5; k++) begin
            cyc((k % 2) == 0, (k % 2) == 1, (k % 2) == 0, 8'h00, 8'h01);
        end
        chk("hold_rv", report_valid, 1);
        chk("hold_samples", samples, 4);
        chk("hold_errors", errors, 4);
        chk("hold_err_bits", err_bits, 8'hFF);
        chk("hold_fec", first_err_cycle, 0);
        drain();
        chk("hold_release_rv", report_valid, 0);
        chk("hold_idle_samples", samples, 4);
        $display("txn report hold: released rv=%0d", report_valid);

        // New window clears stats on entry, then reset mid-RUN
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("entry_samples", samples, 0);
        chk("entry_fev", first_err_valid, 0);
        chk("entry_err_bits", err_bits, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
        cyc(1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
        chk("pre_rst_errors", errors, 2);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        cyc(1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
        reset = 1'b0;
        chk("midrst_samples", samples, 0);
        chk("midrst_errors", errors, 0);
        chk("midrst_mismatch", mismatch, 0);
        chk("midrst_fev", first_err_valid, 0);
        chk("midrst_err_bits", err_bits, 0);
        chk("midrst_rv", report_valid, 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("idle_stop_rv", report_valid, 0);
        $display("txn reset mid-run: samples=%0d rv=%0d", samples, report_valid);

        // start and stop together: enters RUN, stop dropped
        cyc(1'b1, 1'b1, 1'b1, 8'hAA, 8'h55);
        chk("ss_rv0", report_valid, 0);
        chk("ss_samples0", samples, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'hAA, 8'h55);
        chk("ss_rv1", report_valid, 0);
        chk("ss_samples1", samples, 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("ss_report", report_valid, 1);
        chk("ss_errors", errors, 1);
        drain();
        $display("txn start+stop: samples=%0d errors=%0d", samples, errors);

        // Saturation on the CNT_W=4 instance: 20 mismatching samples
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, i == 19, 1'b1, 8'h00, 8'h0F);
            if (i == 14) chk("sat_samples_15", samples4, 15);
            if (i == 15) chk("sat_samples_16", samples4, 15);
        end
        chk("sat_rv4", report_valid4, 1);
        chk("sat_samples4", samples4, 15);
        chk("sat_errors4", errors4, 15);
        chk("sat_fec4", first_err_cycle4, 0);
        chk("sat_err_bits4", err_bits4, 8'h0F);
        chk("sat_samples16", samples, 20);
        chk("sat_errors16", errors, 20);
        drain();
        chk("sat_idle_rv4", report_valid4, 0);
        $display("txn saturation: samples4=%0d errors4=%0d", samples4, errors4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
